kernel_coef_seq: RTL and testbench

//   Sequencer for the 5x5 convolution kernel coefficient ROM (rom5x5).
//   On start it walks ROM addresses 0..24 in raster order, absorbs the ROM's one-cycle read latency,
//   and streams coefficients with row/col tags to the convolution MAC over a valid/ready interface.

---
 rtl/kernel_coef_seq_pkg.sv | 13 +
 rtl/kernel_coef_seq_skid_buf.sv | 70 +++++++
 rtl/kernel_coef_seq.sv | 172 +++++++++++++++++
 tb/tb_kernel_coef_seq.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_coef_seq_pkg.sv
// Shared constants and FSM state type for the 5x5 kernel coefficient sequencer.
package kernel_pkg;
  localparam int KSIZE  = 5;
  localparam int NTAPS  = 25;
  localparam int ADDR_W = 5;
  localparam int RC_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;
endpackage

// File: rtl/kernel_coef_seq_skid_buf.sv
// Small register FIFO that absorbs ROM read latency in front of the coefficient stream.
// Caller guarantees no push when full and no pop when empty; flush dominates push/pop.
module coef_skid_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 31
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign empty     = (count_q == '0);
endmodule

// File: rtl/kernel_coef_seq.sv
// Walks the 5x5 coefficient ROM in raster order and streams tagged taps over valid/ready.
// Optional build macro: KERNEL_SUM_EN adds a running sum of transferred coefficients.
module kernel_coef_seq
  import kernel_pkg::*;
#(
  parameter int COEF_W = 24,
  parameter int BUF_D  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COEF_W-1:0] rom_data,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [COEF_W-1:0] coef_data,
  output logic [RC_W-1:0]   coef_row,
  output logic [RC_W-1:0]   coef_col,
  output logic              coef_last,
  output logic [COEF_W+4:0] kernel_sum
);
  localparam int CW = $clog2(BUF_D + 1);
  localparam int EW = COEF_W + 2 * RC_W + 1;

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RC_W-1:0]   row_q, row_d, col_q, col_d;
  logic              infl_q, infl_d;
  logic              infl_last_q, infl_last_d;
  logic [RC_W-1:0]   infl_row_q, infl_row_d, infl_col_q, infl_col_d;
  logic              done_q, done_d;

  logic              flush, push, pop, issue_last, credit_ok;
  logic [CW:0]       used;
  logic [CW-1:0]     buf_count;
  logic              buf_empty;
  logic [EW-1:0]     head;

  assign pop        = coef_valid & coef_ready;
  // Credits count the read in flight plus buffered entries, minus the one leaving this cycle.
  assign used       = (CW+1)'(infl_q) + {1'b0, buf_count} - (CW+1)'(pop);
  assign credit_ok  = used < (CW+1)'(BUF_D);
  assign rom_rd_en  = (state_q == RUN) && (addr_q < ADDR_W'(NTAPS)) && credit_ok;
  assign rom_addr   = addr_q;
  assign issue_last = (addr_q == ADDR_W'(NTAPS - 1));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    row_d       = row_q;
    col_d       = col_q;
    infl_d      = rom_rd_en;
    infl_row_d  = row_q;
    infl_col_d  = col_q;
    infl_last_d = issue_last;
    done_d      = 1'b0;
    flush       = 1'b0;
    push        = infl_q;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      flush   = 1'b1;
      push    = 1'b0;
      infl_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = RUN;
            addr_d  = '0;
            row_d   = '0;
            col_d   = '0;
          end
        end
        RUN: begin
          if (rom_rd_en) begin
            if (issue_last) begin
              state_d = DRAIN;
            end else begin
              addr_d = addr_q + 1'b1;
              if (col_q == RC_W'(KSIZE - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
          end
        end
        DRAIN: begin
          if (pop && coef_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      infl_row_q  <= '0;
      infl_col_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      infl_row_q  <= infl_row_d;
      infl_col_q  <= infl_col_d;
      done_q      <= done_d;
    end
  end

  coef_skid_buf #(
    .DEPTH (BUF_D),
    .W     (EW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data ({infl_last_q, infl_row_q, infl_col_q, rom_data}),
    .pop       (pop),
    .head_data (head),
    .count     (buf_count),
    .empty     (buf_empty)
  );

  assign {coef_last, coef_row, coef_col, coef_data} = head;
  assign coef_valid = !buf_empty;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

`ifdef KERNEL_SUM_EN
  logic [COEF_W+4:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == IDLE && start && !abort) begin
      sum_d = '0;
    end else if (pop) begin
      sum_d = sum_q + (COEF_W+5)'(coef_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign kernel_sum = sum_q;
`else
  assign kernel_sum = '0;
`endif
endmodule

// File: tb/tb_kernel_coef_seq.sv
// Bench for kernel_coef_seq: ROM model, directed scenarios plus randomized ready/ROM contents,
// with a transaction-level monitor comparing every transfer against the raster-order tap list.
module tb_kernel_coef_seq;
  localparam int COEF_W = 24;
  localparam int BUF_D  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              coef_ready = 1'b0;
  logic              busy, done, rom_rd_en, coef_valid, coef_last;
  logic [4:0]        rom_addr;
  logic [COEF_W-1:0] rom_data = '0;
  logic [COEF_W-1:0] coef_data;
  logic [2:0]        coef_row, coef_col;
  logic [COEF_W+4:0] kernel_sum;

  logic [COEF_W-1:0] rom [25];
  int kdef [25] = '{1, 3, 4, 3, 1, 3, 12, 19, 12, 3, 4, 19, 32, 19, 4,
                    3, 12, 19, 12, 3, 1, 3, 4, 3, 1};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  kernel_coef_seq #(.COEF_W(COEF_W), .BUF_D(BUF_D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rom_rd_en  (rom_rd_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_data  (coef_data),
    .coef_row   (coef_row),
    .coef_col   (coef_col),
    .coef_last  (coef_last),
    .kernel_sum (kernel_sum)
  );

  // rom5x5 behaviour: registered read, one cycle latency.
  always @(posedge clk) if (rom_rd_en) rom_data <= rom[rom_addr];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] tap_word(input int i);
    return {(i == 24), 3'(i / 5), 3'(i % 5), rom[i]};
  endfunction

  function automatic logic [28:0] ksum_model();
    logic [28:0] s = '0;
    for (int i = 0; i < 25; i++) s += 29'(rom[i]);
`ifdef KERNEL_SUM_EN
    return s;
`else
    return '0;
`endif
  endfunction

  // Monitor: expected stream is taps 0..24 in order, with a done pulse one cycle after the last.
  bit          active = 0, exp_done = 0, prev_stall = 0;
  int          exp_tap = 0, exp_addr = 0, outst = 0;
  logic [30:0] prev_word = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0; exp_done = 0; prev_stall = 0;
    end else begin
      if (done || exp_done) check_val("done_pulse", done, exp_done);
      if (exp_done) check_val("kernel_sum", kernel_sum, ksum_model());
      exp_done = 0;
      if (busy && abort) begin
        active = 0; prev_stall = 0;
      end else if (!busy && start) begin
        active = 1; exp_tap = 0; exp_addr = 0; outst = 0; prev_stall = 0;
      end else if (active) begin
        if (prev_stall)
          check_val("hold", {coef_valid, coef_last, coef_row, coef_col, coef_data}, {1'b1, prev_word});
        if (rom_rd_en) begin
          check_val("rd_addr", rom_addr, exp_addr);
          exp_addr++; outst++;
        end
        if (coef_valid && coef_ready) begin
          if (exp_tap < 25) begin
            check_val("xfer_tap", {coef_last, coef_row, coef_col, coef_data}, tap_word(exp_tap));
            $display("xfer tap=%0d row=%0d col=%0d data=0x%0h last=%0b",
                     exp_tap, coef_row, coef_col, coef_data, coef_last);
          end else begin
            check_val("extra_xfer", exp_tap, 24);
          end
          if (exp_tap == 24) begin exp_done = 1; active = 0; end
          exp_tap++; outst--;
        end
        if (rom_rd_en) check_val("credit_limit", (outst <= BUF_D), 1);
        prev_stall = coef_valid && !coef_ready;
        prev_word  = {coef_last, coef_row, coef_col, coef_data};
      end else if (!busy) begin
        check_val("idle_rd_en", rom_rd_en, 0);
      end
    end
  end

  task automatic load_rom(input bit rnd);
    for (int i = 0; i < 25; i++)
      rom[i] = rnd ? COEF_W'($urandom) : COEF_W'(kdef[i]);
  endtask

  // Called at posedge+1; start is sampled on the following edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_until_done(input int mode);
    bit seen = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
      case (mode)
        0:       coef_ready = 1'b1;
        1:       coef_ready = ~coef_ready;
        default: coef_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
    if (!seen) check_val("done_timeout", 0, 1);
  endtask

  task automatic wait_head(input int r, input int c, output bit found);
    found = 0;
    for (int k = 0; k < 80 && !found; k++) begin
      @(posedge clk); #1;
      if (coef_valid && coef_row == 3'(r) && coef_col == 3'(c)) found = 1;
    end
  endtask

  initial begin
    int first_v, done_at;
    bit found;
    first_v = 0; done_at = 0; found = 0;

    load_rom(0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_outs", {done, rom_rd_en, coef_valid, coef_last, rom_addr}, 0);
    check_val("rst_data", {coef_data, coef_row, coef_col}, 0);
    check_val("rst_ksum", kernel_sum, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-rate pass with latency checks relative to the start edge.
    coef_ready = 1'b1;
    pulse_start();
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_val("lat_rd_en", rom_rd_en, 1);
        check_val("lat_addr0", rom_addr, 0);
      end
      if (coef_valid && first_v == 0) first_v = k;
      if (done) begin done_at = k; break; end
    end
    check_val("lat_first_valid", first_v, 3);
    check_val("lat_done", done_at, 28);
    @(negedge clk);
    check_val("busy_after_done", busy, 0);
    @(posedge clk); #1;

    // Alternating ready.
    coef_ready = 1'b0;
    pulse_start();
    run_until_done(1);
    repeat (2) @(posedge clk);
    #1;

    // Long stall with tap 7 at the head.
    coef_ready = 1'b1;
    pulse_start();
    wait_head(1, 2, found);
    check_val("tap7_found", found, 1);
    coef_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("stall_data", coef_data, 24'h13);
      if (i == 0) check_val("stall_rc", {coef_row, coef_col}, {3'd1, 3'd2});
      if (i >= 2) check_val("stall_rd_en", rom_rd_en, 0);
    end
    @(posedge clk); #1;
    coef_ready = 1'b1;
    run_until_done(0);
    repeat (2) @(posedge clk);
    #1;

    // Abort with tap 12 presented, then a clean restart.
    pulse_start();
    wait_head(2, 2, found);
    check_val("tap12_found", found, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_val("abort_valid", coef_valid, 0);
    check_val("abort_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_val("abort_no_done", done, 0);
    end
    pulse_start();
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk); #1;
      if (coef_valid) found = 1;
    end
    check_val("restart_valid", found, 1);
    check_val("restart_tap0", {coef_row, coef_col, coef_data}, {3'd0, 3'd0, 24'd1});
    run_until_done(0);
    repeat (2) @(posedge clk);
    #1;

    // Start while busy is ignored; async reset mid-stream.
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    check_val("busy_mid", busy, 1);
    pulse_start();
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_ctrl", {busy, done, coef_valid, rom_rd_en, coef_last}, 0);
    check_val("arst_data", {coef_data, coef_row, coef_col, rom_addr}, 0);
    check_val("arst_ksum", kernel_sum, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    run_until_done(2);
    repeat (2) @(posedge clk);
    #1;

    // Randomized ROM contents and ready patterns.
    for (int p = 0; p < 4; p++) begin
      load_rom(1);
      coef_ready = 1'b0;
      pulse_start();
      run_until_done((p % 2 == 0) ? 2 : 1);
      repeat (2) @(posedge clk);
      #1;
    end

    // Default kernel sum.
    load_rom(0);
    coef_ready = 1'b1;
    pulse_start();
    run_until_done(0);
`ifdef KERNEL_SUM_EN
    check_val("ksum_default", kernel_sum, 200);
`else
    check_val("ksum_default", kernel_sum, 0);
`endif
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
